// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state, owner and counter-width definitions for mem_arbiter.
package mem_arb_pkg;
   typedef enum logic [1:0] {IDLE, GRANT, RESP} state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} owner_t;
   localparam int DSTREAK_W = 4;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between fetch and data stages,
// data first, with fetch guaranteed a grant after MAX_DSTREAK data wins.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MAX_DSTREAK = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              if_ack_o,
   output logic [DATA_W-1:0] if_rdata_o,
   input  logic              dm_req_i,
   input  logic              dm_we_i,
   input  logic [ADDR_W-1:0] dm_addr_i,
   input  logic [DATA_W-1:0] dm_wdata_i,
   output logic              dm_ack_o,
   output logic [DATA_W-1:0] dm_rdata_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic              mem_ack_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              stall_o
);
   localparam logic [DSTREAK_W-1:0] MAX_DS = DSTREAK_W'(MAX_DSTREAK);
   state_t                 state_q, state_d;
   owner_t                 owner_q, owner_d;
   logic [DSTREAK_W-1:0]   dstreak_q, dstreak_d;
   logic                   mem_req_q, mem_req_d, mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]      mem_wdata_q, mem_wdata_d;
   logic                   if_ack_q, if_ack_d, dm_ack_q, dm_ack_d;
   logic [DATA_W-1:0]      if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
   logic                   dm_wins;
   assign dm_wins = dm_req_i & (~if_req_i | (dstreak_q != MAX_DS));
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      dstreak_d   = dstreak_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_ack_d    = 1'b0;
      dm_ack_d    = 1'b0;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;
      case (state_q)
         IDLE: begin
            if (dm_wins) begin
               owner_d     = OWN_DM;
               mem_req_d   = 1'b1;
               mem_we_d    = dm_we_i;
               mem_addr_d  = dm_addr_i;
               mem_wdata_d = dm_wdata_i;
               state_d     = GRANT;
               dstreak_d   = (if_req_i && dstreak_q != MAX_DS) ? dstreak_q + 4'd1 : dstreak_q;
            end else if (if_req_i) begin
               owner_d    = OWN_IF;
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = if_addr_i;
               state_d    = GRANT;
               dstreak_d  = '0;
            end
         end
         GRANT: begin
            if (mem_ack_i) begin
               mem_req_d  = 1'b0;
               state_d    = RESP;
               if_ack_d   = (owner_q == OWN_IF);
               dm_ack_d   = (owner_q == OWN_DM);
               if_rdata_d = (owner_q == OWN_IF) ? mem_rdata_i : if_rdata_q;
               dm_rdata_d = (owner_q == OWN_DM) ? mem_rdata_i : dm_rdata_q;
            end
         end
         RESP: begin
            state_d = IDLE;
            owner_d = OWN_NONE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= IDLE;
         owner_q     <= OWN_NONE;
         dstreak_q   <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_ack_q    <= 1'b0;
         dm_ack_q    <= 1'b0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         dstreak_q   <= dstreak_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_ack_q    <= if_ack_d;
         dm_ack_q    <= dm_ack_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
      end
   end
   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign if_ack_o    = if_ack_q;
   assign dm_ack_o    = dm_ack_q;
   assign if_rdata_o  = if_rdata_q;
   assign dm_rdata_o  = dm_rdata_q;
   assign stall_o     = (if_req_i & ~if_ack_q) | (dm_req_i & ~dm_ack_q);
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;
   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        if_req_i, dm_req_i, dm_we_i, mem_ack_i;
   logic [31:0] if_addr_i, dm_addr_i, dm_wdata_i, mem_rdata_i;
   logic        if_ack_o, dm_ack_o, mem_req_o, mem_we_o, stall_o;
   logic [31:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o;
   int          tests = 0;
   int          fails = 0;
   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DSTREAK(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ack_o(if_ack_o), .if_rdata_o(if_rdata_o),
      .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
      .dm_ack_o(dm_ack_o), .dm_rdata_o(dm_rdata_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .stall_o(stall_o)
   );
   always #5 clk_i = ~clk_i;
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask
   initial begin
      rst_i = 1'b0; if_req_i = 0; dm_req_i = 0; dm_we_i = 0; mem_ack_i = 0;
      if_addr_i = 0; dm_addr_i = 0; dm_wdata_i = 0; mem_rdata_i = 0;
      step(); step();
      chk("rst_mem_req", {31'd0, mem_req_o}, 0);
      chk("rst_mem_we", {31'd0, mem_we_o}, 0);
      chk("rst_mem_addr", mem_addr_o, 0);
      chk("rst_mem_wdata", mem_wdata_o, 0);
      chk("rst_acks", {30'd0, if_ack_o, dm_ack_o}, 0);
      chk("rst_rdata", if_rdata_o | dm_rdata_o, 0);
      chk("rst_stall", {31'd0, stall_o}, 0);
      rst_i = 1'b1;
      step();
      // lone fetch, memory acks two cycles after mem_req_o rises
      if_req_i = 1; if_addr_i = 32'h10;
      #1 chk("f_stall_idle", {31'd0, stall_o}, 1);
      step();
      chk("f_mem_req", {31'd0, mem_req_o}, 1);
      chk("f_mem_addr", mem_addr_o, 32'h10);
      chk("f_mem_we", {31'd0, mem_we_o}, 0);
      step();
      chk("f_wait_ack", {31'd0, if_ack_o}, 0);
      chk("f_stall_grant", {31'd0, stall_o}, 1);
      step();
      mem_ack_i = 1; mem_rdata_i = 32'h8C22_0004;
      step();
      mem_ack_i = 0;
      chk("f_if_ack", {31'd0, if_ack_o}, 1);
      chk("f_if_rdata", if_rdata_o, 32'h8C22_0004);
      chk("f_mem_req_drop", {31'd0, mem_req_o}, 0);
      chk("f_stall_ack", {31'd0, stall_o}, 0);
      step();
      if_req_i = 0;
      chk("f_ack_pulse", {31'd0, if_ack_o}, 0);
      step();
      chk("f_no_reserve", {31'd0, mem_req_o}, 0);
      // store
      dm_req_i = 1; dm_we_i = 1; dm_addr_i = 32'h20; dm_wdata_i = 32'hDEAD_BEEF;
      step();
      chk("s_mem_req", {31'd0, mem_req_o}, 1);
      chk("s_mem_we", {31'd0, mem_we_o}, 1);
      chk("s_mem_addr", mem_addr_o, 32'h20);
      chk("s_mem_wdata", mem_wdata_o, 32'hDEAD_BEEF);
      mem_ack_i = 1; mem_rdata_i = 32'h1234_5678;
      step();
      mem_ack_i = 0;
      chk("s_dm_ack", {31'd0, dm_ack_o}, 1);
      chk("s_if_ack", {31'd0, if_ack_o}, 0);
      chk("s_if_rdata_kept", if_rdata_o, 32'h8C22_0004);
      step();
      dm_req_i = 0; dm_we_i = 0;
      chk("s_dm_ack_pulse", {31'd0, dm_ack_o}, 0);
      step();
      // simultaneous requests, zero-wait memory
      if_req_i = 1; if_addr_i = 32'h44; dm_req_i = 1; dm_addr_i = 32'h80;
      step();
      chk("b_data_first", mem_addr_o, 32'h80);
      chk("b_load_we", {31'd0, mem_we_o}, 0);
      mem_ack_i = 1; mem_rdata_i = 32'hA5A5_0001;
      step();
      mem_ack_i = 0;
      chk("b_dm_ack", {30'd0, if_ack_o, dm_ack_o}, 1);
      chk("b_dm_rdata", dm_rdata_o, 32'hA5A5_0001);
      chk("b_stall_fetch", {31'd0, stall_o}, 1);
      step();
      dm_req_i = 0;
      chk("b_idle", {31'd0, mem_req_o}, 0);
      step();
      chk("b_fetch_grant", mem_addr_o, 32'h44);
      chk("b_fetch_req", {31'd0, mem_req_o}, 1);
      mem_ack_i = 1; mem_rdata_i = 32'h0000_1111;
      step();
      mem_ack_i = 0;
      chk("b_if_ack", {30'd0, if_ack_o, dm_ack_o}, 2);
      chk("b_if_rdata", if_rdata_o, 32'h0000_1111);
      step();
      if_req_i = 0;
      step();
      // starvation: expect D D D D F D D D D F
      if_req_i = 1; if_addr_i = 32'h100; dm_req_i = 1; dm_addr_i = 32'h200;
      for (int k = 0; k < 10; k++) begin
         logic is_f;
         is_f = (k == 4) || (k == 9);
         step();
         chk($sformatf("st_addr_%0d", k), mem_addr_o, is_f ? 32'h100 : 32'h200);
         mem_ack_i = 1; mem_rdata_i = 32'h5000_0000 + k;
         step();
         mem_ack_i = 0;
         chk($sformatf("st_ack_%0d", k), {30'd0, if_ack_o, dm_ack_o}, is_f ? 32'd2 : 32'd1);
         chk($sformatf("st_rdata_%0d", k), is_f ? if_rdata_o : dm_rdata_o, 32'h5000_0000 + k);
         step();
      end
      if_req_i = 0; dm_req_i = 0;
      step();
      // spurious memory ack while idle
      mem_ack_i = 1; mem_rdata_i = 32'hFFFF_FFFF;
      step();
      mem_ack_i = 0;
      chk("sp_acks", {30'd0, if_ack_o, dm_ack_o}, 0);
      chk("sp_mem_req", {31'd0, mem_req_o}, 0);
      chk("sp_if_rdata", if_rdata_o, 32'h5000_0009);
      chk("sp_dm_rdata", dm_rdata_o, 32'h5000_0008);
      step();
      chk("sp_acks_after", {30'd0, if_ack_o, dm_ack_o}, 0);
      // reset during GRANT
      if_req_i = 1; if_addr_i = 32'h300;
      step();
      chk("r_grant", {31'd0, mem_req_o}, 1);
      #2 rst_i = 0;
      #1;
      chk("r_async_drop", {31'd0, mem_req_o}, 0);
      chk("r_rdata_clr", if_rdata_o, 0);
      step();
      chk("r_no_ack", {30'd0, if_ack_o, dm_ack_o}, 0);
      chk("r_held_low", {31'd0, mem_req_o}, 0);
      rst_i = 1;
      step();
      chk("r_reissue_req", {31'd0, mem_req_o}, 1);
      chk("r_reissue_addr", mem_addr_o, 32'h300);
      mem_ack_i = 1; mem_rdata_i = 32'h0000_0077;
      step();
      mem_ack_i = 0;
      chk("r_if_ack", {31'd0, if_ack_o}, 1);
      chk("r_if_rdata", if_rdata_o, 32'h77);
      step();
      if_req_i = 0;
      step();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
